// File: rtl/bram_stream_reader.sv
// Streams a contiguous BRAM region out as one AXI-Stream frame, arithmetically
// right-shifting each word by a per-frame amount. A 2-entry FWFT buffer absorbs backpressure.
module bram_stream_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_length,
  input  logic [5:0]                  cfg_shift,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
  output logic [BRAM_DATA_WIDTH-1:0]  bram_porta_wrdata,
  output logic                        bram_porta_we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BRAM_ADDR_WIDTH-1:0]  len_q, len_d;
  logic [5:0]                  shift_q, shift_d;
  logic                        inflight_q, inflight_d;
  logic                        rd_last_q, rd_last_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [1:0]                  count_q, count_d;
  logic [AXIS_TDATA_WIDTH-1:0] data0_q, data0_d;
  logic [AXIS_TDATA_WIDTH-1:0] data1_q, data1_d;
  logic                        last0_q, last0_d;
  logic                        last1_q, last1_d;

  logic                        pop_s;
  logic                        push_s;
  logic                        issue_s;
  logic [2:0]                  occ_s;
  logic                        is_last_addr_s;
  logic [BRAM_DATA_WIDTH-1:0]  shifted_s;
  logic [AXIS_TDATA_WIDTH-1:0] cap_data_s;

  // Shift amounts at or beyond the word width collapse to a full sign fill.
  function automatic logic [BRAM_DATA_WIDTH-1:0] asr_sat(
    input logic [BRAM_DATA_WIDTH-1:0] d,
    input logic [5:0]                 s
  );
    logic signed [BRAM_DATA_WIDTH-1:0] sd;
    logic [5:0]                        amt;
    sd = d;
    if (32'(s) >= BRAM_DATA_WIDTH) begin
      amt = 6'(BRAM_DATA_WIDTH - 1);
    end else begin
      amt = s;
    end
    return sd >>> amt;
  endfunction

  assign shifted_s  = asr_sat(bram_porta_rddata, shift_q);
  assign cap_data_s = shifted_s[AXIS_TDATA_WIDTH-1:0];

  assign pop_s          = M_AXIS_tvalid & M_AXIS_tready;
  assign push_s         = inflight_q;
  assign occ_s          = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue_s        = (state_q == S_RUN) && (occ_s < (3'd2 + {2'b00, pop_s}));
  assign is_last_addr_s = (addr_q == (len_q - BRAM_ADDR_WIDTH'(1)));

  assign M_AXIS_tvalid     = (count_q != 2'd0);
  assign M_AXIS_tdata      = data0_q;
  assign M_AXIS_tlast      = last0_q & M_AXIS_tvalid;
  assign busy              = busy_q;
  assign done              = done_q;
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = areset;
  assign bram_porta_addr   = addr_q;
  assign bram_porta_wrdata = '0;
  assign bram_porta_we     = 1'b0;

  // Control FSM: frame sequencing, read issue and completion.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    shift_d    = shift_q;
    inflight_d = 1'b0;
    rd_last_d  = rd_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_length != '0) begin
            len_d   = cfg_length;
            shift_d = cfg_shift;
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s) begin
          inflight_d = 1'b1;
          rd_last_d  = is_last_addr_s;
          if (is_last_addr_s) begin
            state_d = S_DRAIN;
          end else begin
            addr_d  = addr_q + BRAM_ADDR_WIDTH'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The final handshake empties the buffer, so done lands the cycle after it.
        if (!inflight_q && (count_d == 2'd0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Two-entry FWFT buffer; entry 0 is always the head.
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case (count_q)
      2'd0: begin
        if (push_s) begin
          data0_d = cap_data_s;
          last0_d = rd_last_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        case ({push_s, pop_s})
          2'b10: begin
            data1_d = cap_data_s;
            last1_d = rd_last_q;
            count_d = 2'd2;
          end
          2'b11: begin
            data0_d = cap_data_s;
            last0_d = rd_last_q;
          end
          2'b01: count_d = 2'd0;
          default: count_d = 2'd1;
        endcase
      end
      2'd2: begin
        if (pop_s) begin
          data0_d = data1_q;
          last0_d = last1_q;
          if (push_s) begin
            data1_d = cap_data_s;
            last1_d = rd_last_q;
          end else begin
            count_d = 2'd1;
          end
        end else begin
          count_d = 2'd2;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // State register for control and buffer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      shift_q    <= 6'd0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 2'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      inflight_q <= inflight_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
    end
  end

endmodule
